// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for two cores' L1 fill/store requests onto a 256x32 data memory
//   LATENCY       ACCESS cycles per request (1..8)
//   clk, reset    clock, synchronous active-high reset
//   req/we        per-core request and store flag (bit k = core k)
//   maskN/addrN/wdataN  per-core access size, byte address, right-aligned store data
//   ack           one-cycle completion pulse for the granted core
//   rdata         full memory word of the completed access (pre-write word for stores)
//   busy          high whenever the FSM is not IDLE
//   inv_valid/inv_addr  snoop invalidate toward the other core; live only with DMEM_SNOOP_INVAL_EN
module dmem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [2:0]  mask0,
  input  logic [2:0]  mask1,
  input  logic [9:0]  addr0,
  input  logic [9:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [1:0]  inv_valid,
  output logic [9:0]  inv_addr
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [2:0] LOAD = 3'(LATENCY - 1);
  state_t state_q, state_d;
  logic gnt_q, gnt_d, prio_q, prio_d, we_q, we_d, busy_q, busy_d;
  logic [2:0] mask_q, mask_d, cnt_q, cnt_d;
  logic [9:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] ack_q, ack_d;
  logic [31:0] mem_q [256];
  logic [31:0] old_word, wsrc, merged;
  logic [3:0] lanes;
  logic pick, done, legal_st;
  // with both cores requesting the pointer decides, otherwise the lone requester wins
  assign pick = &req ? prio_q : req[1];
  assign done = state_q == ACCESS && cnt_q == 3'd0;
  assign legal_st = we_q && !mask_q[2] && mask_q[1:0] != 2'b11;
  assign old_word = mem_q[addr_q[9:2]];
  assign lanes = mask_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                 mask_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // replicate the right-aligned data so every candidate lane sees the right bits
  assign wsrc = mask_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                mask_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = lanes[i] ? wsrc[8*i +: 8] : old_word[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    prio_d = prio_q;
    we_d = we_q;
    mask_d = mask_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    ack_d = 2'b00;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ACCESS;
        gnt_d = pick;
        prio_d = ~pick;
        we_d = we[pick];
        mask_d = pick ? mask1 : mask0;
        addr_d = pick ? addr1 : addr0;
        wdata_d = pick ? wdata1 : wdata0;
        cnt_d = LOAD;
      end
      ACCESS: if (done) begin
        state_d = RESP;
        rdata_d = old_word;
        ack_d = gnt_q ? 2'b10 : 2'b01;
      end else cnt_d = cnt_q - 3'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      prio_q <= 1'b0;
      we_q <= 1'b0;
      mask_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      ack_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      prio_q <= prio_d;
      we_q <= we_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else if (done && legal_st) begin
      mem_q[addr_q[9:2]] <= merged;
    end
  end
  assign ack = ack_q;
  assign rdata = rdata_q;
  assign busy = busy_q;
`ifdef DMEM_SNOOP_INVAL_EN
  logic [1:0] inv_valid_q, inv_valid_d;
  logic [9:0] inv_addr_q, inv_addr_d;
  // the invalidate targets the core that did not perform the store
  always_comb begin
    inv_valid_d = done && legal_st ? (gnt_q ? 2'b01 : 2'b10) : 2'b00;
    inv_addr_d = done && legal_st ? {addr_q[9:2], 2'b00} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_valid_q <= '0;
      inv_addr_q <= '0;
    end else begin
      inv_valid_q <= inv_valid_d;
      inv_addr_q <= inv_addr_d;
    end
  end
  assign inv_valid = inv_valid_q;
  assign inv_addr = inv_addr_q;
`else
  assign inv_valid = '0;
  assign inv_addr = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of dmem_arbiter plus round-robin and reset-abort sequences
module tb_dmem_arbiter;
  localparam int LA = 2;
  localparam int LB = 4;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [1:0] req_a, req_b, we;
  logic [2:0] mask0, mask1;
  logic [9:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0] ack_a, ack_b, inv_valid_a, inv_valid_b;
  logic [31:0] rdata_a, rdata_b;
  logic busy_a, busy_b;
  logic [9:0] inv_addr_a, inv_addr_b;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    bit core;
    bit w;
    logic [2:0] m;
    logic [9:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[14];
  always #5 clk = ~clk;
  dmem_arbiter #(.LATENCY(LA)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .we(we), .mask0(mask0), .mask1(mask1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .inv_valid(inv_valid_a), .inv_addr(inv_addr_a)
  );
  dmem_arbiter #(.LATENCY(LB)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .we(we), .mask0(mask0), .mask1(mask1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .inv_valid(inv_valid_b), .inv_addr(inv_addr_b)
  );
  function automatic logic [1:0] ack_o(input bit s);
    return s ? ack_b : ack_a;
  endfunction
  function automatic logic busy_o(input bit s);
    return s ? busy_b : busy_a;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    we[v.core] = v.w;
    if (v.core) begin
      mask1 = v.m; addr1 = v.a; wdata1 = v.d;
    end else begin
      mask0 = v.m; addr0 = v.a; wdata0 = v.d;
    end
  endtask
  task automatic run(input bit s, input vec_t v);
    int k, busy_n;
    logic legal;
    logic [1:0] exp_inv;
    drive(v);
    if (s) req_b[v.core] = 1'b1; else req_a[v.core] = 1'b1;
    @(posedge clk);
    k = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy_o(s)) busy_n++;
    end while (ack_o(s) == 2'b00 && k < 20);
    legal = v.w && (v.m == 3'b000 || v.m == 3'b001 || v.m == 3'b010);
`ifdef DMEM_SNOOP_INVAL_EN
    exp_inv = legal ? (v.core ? 2'b01 : 2'b10) : 2'b00;
`else
    exp_inv = 2'b00;
`endif
    chk("latency", k, s ? LB + 1 : LA + 1);
    chk("ack", ack_o(s), v.core ? 2'b10 : 2'b01);
    chk("rdata", s ? rdata_b : rdata_a, v.exp);
    chk("busy_cycles", busy_n, s ? LB + 1 : LA + 1);
    if (!s) begin
      chk("inv_valid", inv_valid_a, exp_inv);
      if (exp_inv != 2'b00) chk("inv_addr", inv_addr_a, {v.a[9:2], 2'b00});
    end
    if (s) req_b = 2'b00; else req_a = 2'b00;
    @(negedge clk);
    chk("ack_width", ack_o(s), 2'b00);
    chk("busy_idle", busy_o(s), 1'b0);
    if (!s) chk("inv_width", inv_valid_a, 2'b00);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int t, n, k, acks;
    logic [1:0] prev;
    logic [1:0] got[4];
    int at[4];
    tv[0]  = '{0, 0, 3'b010, 10'h010, 32'h0, 32'h0};
    tv[1]  = '{1, 1, 3'b010, 10'h104, 32'hDEADBEEF, 32'h0};
    tv[2]  = '{1, 1, 3'b000, 10'h106, 32'h00000055, 32'hDEADBEEF};
    tv[3]  = '{0, 0, 3'b010, 10'h104, 32'h0, 32'hDE55BEEF};
    tv[4]  = '{0, 1, 3'b001, 10'h203, 32'h0000ABCD, 32'h0};
    tv[5]  = '{1, 0, 3'b010, 10'h200, 32'h0, 32'hABCD0000};
    tv[6]  = '{0, 1, 3'b011, 10'h104, 32'hFFFFFFFF, 32'hDE55BEEF};
    tv[7]  = '{1, 0, 3'b100, 10'h104, 32'h0, 32'hDE55BEEF};
    tv[8]  = '{0, 1, 3'b001, 10'h104, 32'hFFFF1234, 32'hDE55BEEF};
    tv[9]  = '{0, 0, 3'b010, 10'h104, 32'h0, 32'hDE551234};
    tv[10] = '{1, 1, 3'b000, 10'h107, 32'hAAAAAA77, 32'hDE551234};
    tv[11] = '{1, 0, 3'b101, 10'h105, 32'h0, 32'h77551234};
    tv[12] = '{0, 1, 3'b010, 10'h3A6, 32'hCAFEF00D, 32'h0};
    tv[13] = '{0, 0, 3'b010, 10'h3A4, 32'h0, 32'hCAFEF00D};
    req_a = 2'b00; req_b = 2'b00; we = 2'b00;
    mask0 = '0; mask1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack_a, 2'b00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_inv_valid", inv_valid_a, 2'b00);
    chk("rst_inv_addr", inv_addr_a, 10'h0);
    chk("rst_busy_b", busy_b, 1'b0);
    for (int i = 0; i < 14; i++) run(1'b0, tv[i]);
    // both cores hold read requests from reset: grants alternate, one per LA+2 cycles
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    we = 2'b00; mask0 = 3'b010; mask1 = 3'b010; addr0 = 10'h104; addr1 = 10'h200;
    req_a = 2'b11;
    t = 0; n = 0; prev = 2'b00;
    while (n < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (ack_a != 2'b00) begin
        chk("rr_ack_width", prev, 2'b00);
        got[n] = ack_a;
        at[n] = t;
        n++;
      end
      prev = ack_a;
    end
    req_a = 2'b00;
    chk("rr_count", n, 4);
    for (int i = 0; i < n; i++) chk("rr_grant", got[i], i % 2 ? 2'b10 : 2'b01);
    for (int i = 1; i < n; i++) chk("rr_gap", at[i] - at[i-1], LA + 2);
    repeat (2) @(negedge clk);
    // store aborted by reset in its 2nd ACCESS cycle on the LATENCY=4 instance
    we = 2'b01; mask0 = 3'b010; addr0 = 10'h040; wdata0 = 32'h12345678;
    req_b = 2'b01;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    req_b = 2'b00;
    @(negedge clk);
    rst_b = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_b != 2'b00) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_busy", busy_b, 1'b0);
    // reset must have restored the pointer to core 0
    we = 2'b00; addr1 = 10'h040;
    req_b = 2'b11;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack_b == 2'b00 && k < 20);
    chk("abort_prio", ack_b, 2'b01);
    req_b = 2'b00;
    repeat (2) @(negedge clk);
    run(1'b1, '{0, 0, 3'b010, 10'h040, 32'h0, 32'h0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory stage directly downstream of the per-core L1 data caches. It arbitrates two cores' L1 miss-fill and store requests onto a single word-organised data memory of 256 × 32 bits. Each request is served with a fixed, parameterised access latency, and the word is returned on a one-cycle ack. An optional snoop channel tells the other core's L1 to invalidate a line whenever a store lands.

## Interface
- `LATENCY`, default 2: ACCESS cycles per request; legal range 1..8.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `req` in 2: per-core request; bit k belongs to core k. Held high until `ack[k]` is seen.
- `we` in 2: per-core; 1 = store, 0 = read/fill.
- `mask0`, `mask1` in 3 each: access size. 000 = byte, 001 = half, 010 = word; 100/101 are treated as reads of the full word.
- `addr0`, `addr1` in 10 each: byte address; bits [9:2] select the word.
- `wdata0`, `wdata1` in 32 each: store data, right-aligned.
- `ack` out 2: one-cycle completion pulse for the granted core.
- `rdata` out 32: full memory word of the completed access; valid while `ack` is high.
- `busy` out 1: high in every state except IDLE.
- `inv_valid` out 2: snoop-invalidate pulse, one bit per target core (macro only).
- `inv_addr` out 10: address of the invalidated line (macro only).

## Operation
- Storage: `mem[0:255]`, one 32-bit word per entry, indexed by `addr[9:2]`.
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req` bit is high, grant one core and latch its `we`, `mask`, `addr` and `wdata`. Load the counter with `LATENCY-1` and go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration:** round-robin with a 1-bit priority pointer `prio`, reset to 0.
  - If only one core requests, that core wins.
  - If both request, core `prio` wins.
  - After every grant, `prio` becomes the complement of the granted core.
- **ACCESS**
  - Decrement the counter each cycle.
  - When the counter is 0: for a store, write the merged word into memory; capture `rdata` (the pre-write word for a store, the stored word for a read). Then go to RESP.
- **Store merge** (latched `addr[1:0]` selects lanes; unselected lanes keep their old value):
  - Byte: lane `addr[1:0]` takes `wdata[7:0]`.
  - Half: lanes [15:0] or [31:16] take `wdata[15:0]`, selected by `addr[1]`; `addr[0]` is ignored.
  - Word: all 32 bits are written; `addr[1:0]` is ignored.
  - Any other mask with `we=1`: no write, but `ack` still pulses.
- **RESP:** assert `ack[granted]` for exactly one cycle, then go to IDLE.
- **Request reuse:** a `req` bit still high in the IDLE that follows its ack is treated as a new request. Requesters drop `req` on the edge where they see `ack`.
- `req` bits are ignored in ACCESS and RESP; a new arrival waits until the next IDLE.
- **Reset:**
  - State goes to IDLE and `prio`=0.
  - `ack`, `inv_valid`, `inv_addr`, `rdata` and `busy` all go to 0.
  - All 256 words are cleared to 0.
  - Reset during ACCESS or RESP aborts the request: no write, no ack.

## Timing
- Request sampled in IDLE at edge N. ACCESS occupies cycles N+1..N+LATENCY. `ack` and `rdata` are valid in cycle N+LATENCY+1.
- Total latency from grant to ack is LATENCY+1 cycles. Back-to-back throughput is one request per LATENCY+2 cycles.
- All outputs are registered.
- `rdata` holds its last value after ack until the next RESP.

## Configuration
- Macro: `DMEM_SNOOP_INVAL_EN`.
- **Defined:** in the RESP cycle of a completed store (`we=1` with a legal mask):
  - `inv_valid[other core]` = 1 for exactly one cycle.
  - `inv_addr` = latched `addr` with bits [1:0] forced to 00.
  - No invalidate is issued for reads or illegal-mask stores.
- **Undefined:** `inv_valid` and `inv_addr` are tied to 0. Ports remain present so integration is unchanged.

## Test plan
- **Reset fill:** reset, then core0 reads word `addr=0x010` with LATENCY=2 → `ack[0]` exactly 3 cycles after the grant edge, `rdata=0x00000000`, `busy` high for 3 cycles.
- **Store word then byte:** core1 stores word 0xDEADBEEF to 0x104, then stores byte 0x55 to 0x106 → a following read of 0x104 returns 0xDE55BEEF.
- **Round-robin:** both cores hold `req` continuously with reads, starting from reset → grants alternate 0,1,0,1; `ack` pulses never overlap; each `ack` is one cycle wide.
- **Halfword with misaligned bit:** store half 0xABCD to 0x203 (`addr[0]=1`, ignored) → word 0x200 becomes 0xABCD0000 (upper half written).
- **Reset mid-access:** core0 stores 0x12345678 to 0x040 with LATENCY=4; assert reset in the 2nd ACCESS cycle → no `ack`; a subsequent read of 0x040 returns 0x00000000.
- **Snoop invalidate (`DMEM_SNOOP_INVAL_EN` defined):** core0 stores to 0x3A6 → `inv_valid=2'b10` and `inv_addr=0x3A4` in the ack cycle. A read by core0 produces no invalidate. With the macro undefined, `inv_valid` stays 0 throughout.
